rom_bus_arbiter: RTL and testbench

//  Shares the single ROM read port between two requesters: port 0 (instruction fetch) and port 1 (data/LDE path).

---
 rtl/rom_bus_arbiter.sv | 120 ++++++++++++
 tb/tb_rom_bus_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_bus_arbiter.sv
// Round-robin arbiter that shares one ROM read port between an instruction-fetch
// requester (port 0) and a data/LDE requester (port 1).
module rom_bus_arbiter #(
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int TIMEOUT = 15   // legal range 3..255
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic [AW-1:0] addr0,
    output logic          ack0,
    output logic          err0,
    input  logic          req1,
    input  logic [AW-1:0] addr1,
    output logic          ack1,
    output logic          err1,
    output logic [DW-1:0] rdata,
    output logic          rom_cs,
    output logic [AW-1:0] rom_addr,
    input  logic          rom_ready,
    input  logic [DW-1:0] rom_data,
    output logic          busy,
    output logic          grant
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_LO,
        S_WAIT_HI,
        S_DONE
    } state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic          grant_q, grant_d;
    logic [AW-1:0] rom_addr_q, rom_addr_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          winner;

    always_comb begin
        // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latches).
        state_d    = state_q;
        grant_d    = grant_q;
        rom_addr_d = rom_addr_q;
        rdata_d    = rdata_q;
        cnt_d      = cnt_q;
        err_d      = 1'b0;
        // On a tie the port that was not served last wins; otherwise the lone requester.
        winner     = (req0 && req1) ? ~grant_q : req1;

        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    grant_d    = winner;
                    rom_addr_d = winner ? addr1 : addr0;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT_LO;
            end
            S_WAIT_LO, S_WAIT_HI: begin
                cnt_d = cnt_q + 8'd1;
                // The ROM's idle-high ready is never mistaken for completion: a low must be seen first.
                if (state_q == S_WAIT_LO && !rom_ready) begin
                    state_d = S_WAIT_HI;
                end else if (state_q == S_WAIT_HI && rom_ready) begin
                    rdata_d = rom_data;
                    state_d = S_DONE;
                end else if (cnt_q >= TIMEOUT_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            grant_q    <= 1'b1;
            rom_addr_q <= '0;
            rdata_q    <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rom_addr_q <= rom_addr_d;
            rdata_q    <= rdata_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
        end
    end

    // Outputs decode straight from flops, so they carry no combinational path from the inputs.
    assign rom_cs   = (state_q == S_ISSUE);
    assign busy     = (state_q == S_ISSUE) || (state_q == S_WAIT_LO) || (state_q == S_WAIT_HI);
    assign ack0     = (state_q == S_DONE) && !grant_q;
    assign ack1     = (state_q == S_DONE) && grant_q;
    assign err0     = err_q && !grant_q;
    assign err1     = err_q && grant_q;
    assign rdata    = rdata_q;
    assign rom_addr = rom_addr_q;
    assign grant    = grant_q;

endmodule

// File: tb/tb_rom_bus_arbiter.sv
// Self-checking bench for rom_bus_arbiter: a cycle-level ROM model plus a scoreboard of
// expected ack/err responses, and direct checks of latency, address hold and reset.
module tb_rom_bus_arbiter;

    localparam int AW      = 16;
    localparam int DW      = 16;
    localparam int TIMEOUT = 15;

    typedef struct packed {
        logic          port;
        logic          is_err;
        logic [DW-1:0] data;
    } exp_t;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          req0  = 1'b0;
    logic          req1  = 1'b0;
    logic [AW-1:0] addr0 = '0;
    logic [AW-1:0] addr1 = '0;
    logic          ack0, ack1, err0, err1, rom_cs, busy, grant;
    logic [DW-1:0] rdata;
    logic [AW-1:0] rom_addr;
    logic          rom_ready = 1'b1;
    logic [DW-1:0] rom_data;

    always #5 clk = ~clk;

    rom_bus_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req0     (req0),
        .addr0    (addr0),
        .ack0     (ack0),
        .err0     (err0),
        .req1     (req1),
        .addr1    (addr1),
        .ack1     (ack1),
        .err1     (err1),
        .rdata    (rdata),
        .rom_cs   (rom_cs),
        .rom_addr (rom_addr),
        .rom_ready(rom_ready),
        .rom_data (rom_data),
        .busy     (busy),
        .grant    (grant)
    );

    // ROM model: cs seen -> ready low for one cycle -> ready high with data for one cycle.
    logic [DW-1:0] mem [0:4095];
    logic          stuck        = 1'b0;
    logic [1:0]    rom_phase    = 2'd0;
    logic [AW-1:0] rom_lat_addr = '0;
    logic [DW-1:0] rom_dq       = '0;

    always @(posedge clk) begin
        if (stuck) begin
            rom_ready <= 1'b1;
            rom_phase <= 2'd0;
        end else begin
            case (rom_phase)
                2'd0: if (rom_cs) begin
                    rom_ready    <= 1'b0;
                    rom_lat_addr <= rom_addr;
                    rom_phase    <= 2'd1;
                end
                2'd1: begin
                    rom_ready <= 1'b1;
                    rom_dq    <= mem[rom_lat_addr[11:0]];
                    rom_phase <= 2'd2;
                end
                default: rom_phase <= 2'd0;
            endcase
        end
    end

    // Garbage value stands in for the floating bus whenever data is not valid.
    assign rom_data = (rom_phase == 2'd2) ? rom_dq : 16'hDEAD;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    int cyc      = 0;
    int cs_count = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (rst_n && rom_cs) cs_count <= cs_count + 1;

    exp_t          sb [$];
    exp_t          e;
    logic [DW-1:0] exp_rdata = '0;

    always @(negedge clk) begin
        if (rst_n) begin
            check("resp_exclusive", ($countones({ack0, ack1, err0, err1}) <= 1), 1);
            if (ack0 || ack1 || err0 || err1) begin
                if (sb.size() == 0) begin
                    check("unexpected_resp", {ack0, ack1, err0, err1}, 0);
                end else begin
                    e = sb.pop_front();
                    check("resp_port", (ack1 || err1), e.port);
                    check("resp_kind", (err0 || err1), e.is_err);
                    check("resp_rdata", rdata, e.data);
                    check("resp_grant", grant, e.port);
                end
            end
        end
    end

    task automatic expect_ack(input logic port, input logic [AW-1:0] addr);
        exp_rdata = mem[addr[11:0]];
        sb.push_back('{port, 1'b0, exp_rdata});
    endtask

    task automatic expect_err(input logic port);
        sb.push_back('{port, 1'b1, exp_rdata});
    endtask

    task automatic wait_cs(output int at);
        at = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rom_cs) begin
                at = cyc;
                return;
            end
        end
        check("cs_wait_expired", 0, 1);
    endtask

    task automatic wait_resp(output int at);
        at = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (ack0 || ack1 || err0 || err1) begin
                at = cyc;
                return;
            end
        end
        check("resp_wait_expired", 0, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req0  = 1'b0;
        req1  = 1'b0;
        repeat (2) @(negedge clk);
        sb.delete();
        exp_rdata = '0;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, tc, tr, cs0;
        for (int i = 0; i < 4096; i++) mem[i] = 16'h1000 + 16'(i);
        mem[0]   = 16'h0028;
        mem[1]   = 16'h000A;
        mem[2]   = 16'h0034;
        mem[200] = 16'h0029;

        do_reset();
        check("rst_outputs", {ack0, ack1, err0, err1, rom_cs, busy}, 0);
        check("rst_rdata", rdata, 0);
        check("rst_rom_addr", rom_addr, 0);
        check("rst_grant", grant, 1);

        // Single port-0 read: cs one cycle after request, ack four cycles after.
        @(negedge clk);
        req0 = 1'b1; addr0 = 16'd0; t0 = cyc; cs0 = cs_count;
        expect_ack(1'b0, 16'd0);
        wait_cs(tc);
        check("t1_cs_latency", tc - t0, 1);
        check("t1_rom_addr", rom_addr, 0);
        check("t1_busy", busy, 1);
        wait_resp(tr);
        req0 = 1'b0;
        check("t1_ack_latency", tr - t0, 4);
        check("t1_busy_done", busy, 0);
        check("t1_cs_count", cs_count - cs0, 1);

        // Simultaneous requests after reset: port 0 first, then port 1.
        do_reset();
        @(negedge clk);
        req0 = 1'b1; addr0 = 16'd1;
        req1 = 1'b1; addr1 = 16'd200;
        expect_ack(1'b0, 16'd1);
        expect_ack(1'b1, 16'd200);
        wait_resp(tr);
        req0 = 1'b0;
        wait_resp(tr);
        req1 = 1'b0;

        // Both held: strict alternation, one cs per ack.
        @(negedge clk);
        cs0 = cs_count;
        req0 = 1'b1; addr0 = 16'd5;
        req1 = 1'b1; addr1 = 16'd6;
        for (int k = 0; k < 2; k++) begin
            expect_ack(1'b0, 16'd5);
            expect_ack(1'b1, 16'd6);
        end
        for (int k = 0; k < 4; k++) wait_resp(tr);
        req0 = 1'b0; req1 = 1'b0;
        check("t3_cs_count", cs_count - cs0, 4);

        // Stuck-ready ROM: timeout error 16 cycles after cs, rdata untouched.
        stuck = 1'b1;
        @(negedge clk);
        req0 = 1'b1; addr0 = 16'd3;
        expect_err(1'b0);
        wait_cs(tc);
        wait_resp(tr);
        req0 = 1'b0;
        stuck = 1'b0;
        check("t4_err_latency", tr - tc, 16);
        check("t4_grant", grant, 0);

        // After the timeout on port 0, a tie goes to port 1.
        @(negedge clk);
        req0 = 1'b1; addr0 = 16'd8;
        req1 = 1'b1; addr1 = 16'd9;
        expect_ack(1'b1, 16'd9);
        expect_ack(1'b0, 16'd8);
        wait_resp(tr);
        req1 = 1'b0;
        wait_resp(tr);
        req0 = 1'b0;

        // Reset during WAIT_HI: outputs clear at once, a fresh request then completes.
        @(negedge clk);
        req1 = 1'b1; addr1 = 16'd7;
        wait_cs(tc);
        @(negedge clk);
        @(negedge clk);
        check("t5_busy_before_reset", busy, 1);
        rst_n = 1'b0;
        #1;
        check("t5_rst_outputs", {ack0, ack1, err0, err1, rom_cs, busy}, 0);
        check("t5_rst_rdata", rdata, 0);
        check("t5_rst_grant", grant, 1);
        req1 = 1'b0;
        repeat (2) @(negedge clk);
        exp_rdata = '0;
        rst_n = 1'b1;
        @(negedge clk);
        req1 = 1'b1; addr1 = 16'd7;
        expect_ack(1'b1, 16'd7);
        wait_resp(tr);
        req1 = 1'b0;

        // Address changes and request drops mid-access: held address, ack still pulsed.
        @(negedge clk);
        req0 = 1'b1; addr0 = 16'd2;
        expect_ack(1'b0, 16'd2);
        wait_cs(tc);
        @(negedge clk);
        addr0 = 16'd4;
        req0  = 1'b0;
        wait_resp(tr);
        check("t6_rom_addr_held", rom_addr, 2);
        check("t6_ack_latency", tr - tc, 3);

        repeat (3) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
